jacobi_pivot_search: RTL and testbench
======================================

Name: jacobi_pivot_search

Overview:
- Upstream feeder for the data query engine / CORDIC path in the Jacobi eigen-solver.
- On `start`, reads the covariance matrix from the covariance BRAM read port and scans the strict upper triangle for the off-diagonal element with the largest magnitude.
- Then fetches the two matching diagonal entries and presents p, q, c_pp, c_qq and c_pq with a one-cycle valid pulse.
- That pulse drives the CORDIC arctan-valid input; a convergence flag tells the sweep controller to stop rotating.

Parameters:
- DATA_SIZE, 8, bit width of one matrix element (two's complement); selected from bits [DATA_SIZE-1:0] of the BRAM word.
- MATRIX_SIZE, 4, matrix dimension N. The row-major address of element (r,c) is r*N+c.
- ADDR_W, 4, BRAM address width; must satisfy 2^ADDR_W >= N*N.
- READ_LATENCY, 1, cycles from `ena_cov`/`addra_cov` to valid `douta_cov`; allowed range 1..3.
- THRESHOLD, 1, unsigned magnitude. A best |c_pq| strictly below this value means converged.

Ports:
- clk, input, 1, system clock; all logic is rising-edge.
- rst, input, 1, asynchronous active-low reset: asserts immediately, releases synchronously to clk.
- start, input, 1, begin one pivot search; sampled only in IDLE.
- douta_cov, input, 32, covariance BRAM read data.
- ena_cov, output, 1, BRAM read enable.
- addra_cov, output, ADDR_W, BRAM read address.
- p, output, 2, pivot row index (clog2(N) bits).
- q, output, 2, pivot column index (clog2(N) bits), with q > p.
- c_pp, output, DATA_SIZE, diagonal element (p,p).
- c_qq, output, DATA_SIZE, diagonal element (q,q).
- c_pq, output, DATA_SIZE, pivot element (p,q), signed and unmodified.
- pivot_valid, output, 1, one-cycle pulse: pivot outputs valid and rotation required.
- done, output, 1, one-cycle pulse at the end of every search.
- converged, output, 1, level signal: best magnitude < THRESHOLD. Updated at `done`.
- busy, output, 1, high from the cycle after `start` is accepted until `done` inclusive.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Best candidate is (p=0, q=1) with magnitude 0.
- States: IDLE → SCAN → DRAIN → DIAG → DIAG_DRAIN → REPORT → IDLE.
- IDLE:
  - `start`=1 → SCAN.
  - The best register is cleared to magnitude 0, (0,1).
- SCAN:
  - Issues N*(N-1)/2 reads, one per cycle, in order (0,1),(0,2),(0,3),(1,2),(1,3),(2,3). With defaults these are addresses 1,2,3,6,7,11.
  - `ena_cov`=1 on each issue cycle.
  - A pair-index shift register of depth READ_LATENCY tags every returning word.
- Compare step, on each returning word:
  - mag = saturating |x|; x=-2^(DATA_SIZE-1) gives 2^(DATA_SIZE-1)-1 (-128 gives 127).
  - Replace the best entry only if mag > best_mag (strict), so the earliest pair wins ties.
  - Store the signed raw value as c_pq.
- DRAIN: wait READ_LATENCY cycles for the last scan word, with `ena_cov`=0.
- DIAG:
  - Issue address p*N+p, then q*N+q, on two consecutive cycles, using the final best (p,q).
- DIAG_DRAIN: capture c_pp and c_qq as their data returns.
- REPORT: one cycle, then → IDLE.
  - `done`=1.
  - `pivot_valid` = ~converged_next.
  - `converged` = (best_mag < THRESHOLD).
- Output holding:
  - p, q, c_pp, c_qq and c_pq are registered.
  - They hold their values after REPORT until the next search's REPORT.
  - Outputs never change mid-search.
- Latency: `start` is sampled at edge 0; `done` is high in cycle N(N-1)/2 + 2*READ_LATENCY + 3. With defaults this is cycle 11.
- A `start` pulse while busy is ignored and is not queued.
- A `start` held high in REPORT is not accepted until IDLE; the next search begins one cycle after REPORT.
- If rst asserts mid-search, the block immediately returns to the reset values. No `done` pulse is emitted.
- All off-diagonals zero: pivot stays (0,1), c_pq=0, `converged`=1, `pivot_valid`=0, `done`=1.
- The upper 32-DATA_SIZE bits of `douta_cov` are ignored.

Decomposition:
- pca_pkg holds:
  - DATA_SIZE and MATRIX_SIZE defaults.
  - The pivot-state enum.
  - A function mapping pair index to (p,q).
  - A function mapping (r,c) to a row-major address.
- Sub-module abs_sat: combinational saturating magnitude, DATA_SIZE in, DATA_SIZE out. It is instantiated once in the compare step.

Test Plan:
- Identity-like matrix with off-diagonals 0, diagonals 10 → `done` at cycle 11; `converged`=1; `pivot_valid`=0; p=0, q=1.
- Off-diagonal (1,3)=-50, others ≤ 20, diagonals c11=30, c33=-7 → p=1, q=3, c_pq=-50 (0xCE), c_pp=30, c_qq=-7 (0xF9); `pivot_valid` pulse exactly one cycle.
- Tie: (0,2)=40 and (2,3)=-40 → p=0, q=2 (first wins); `addra_cov` sequence 1,2,3,6,7,11,0,10.
- Element (1,2)=-128 among values ≤ 100 → pivot (1,2), magnitude treated as 127, c_pq output = 0x80.
- `start` pulsed again at cycle 4, then rst low at cycle 6 → second start ignored; all outputs 0 immediately; no `done`; a fresh start afterwards completes normally.
- READ_LATENCY=2 build with the same matrix as test 2 → identical results; `done` at cycle 13.

Source files
------------

// File: rtl/pca_pkg.sv
// Shared types and index helpers for the Jacobi pivot search.
// Covers default sizes, the FSM/read-tag enums and the pair/address mapping functions.
package pca_pkg;

    localparam int PCA_DATA_SIZE   = 8;
    localparam int PCA_MATRIX_SIZE = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DIAG,
        ST_DIAG_DRAIN,
        ST_REPORT
    } pivot_state_e;

    // Kind of read currently travelling through the BRAM latency pipe
    typedef enum logic [1:0] {
        RD_NONE,
        RD_SCAN,
        RD_PP,
        RD_QQ
    } read_kind_e;

    // Upper-triangle pairs are numbered row-major: (0,1),(0,2),...,(n-2,n-1)
    function automatic int pair_row(input int idx, input int n);
        int k;
        int row;
        k   = 0;
        row = 0;
        for (int r = 0; r < n - 1; r++) begin
            for (int c = r + 1; c < n; c++) begin
                if (k == idx) row = r;
                k++;
            end
        end
        return row;
    endfunction

    function automatic int pair_col(input int idx, input int n);
        int k;
        int col;
        k   = 0;
        col = 1;
        for (int r = 0; r < n - 1; r++) begin
            for (int c = r + 1; c < n; c++) begin
                if (k == idx) col = c;
                k++;
            end
        end
        return col;
    endfunction

    function automatic int rc_addr(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/abs_sat.sv
// Saturating two's-complement magnitude: the most negative code maps to the
// largest positive code so the result always fits in the input width.
module abs_sat
    import pca_pkg::*;
#(
    parameter int DATA_SIZE = PCA_DATA_SIZE
)(
    input  logic [DATA_SIZE-1:0] i_val,
    output logic [DATA_SIZE-1:0] o_mag
);

    localparam logic [DATA_SIZE-1:0] MOST_NEG = {1'b1, {(DATA_SIZE-1){1'b0}}};
    localparam logic [DATA_SIZE-1:0] MOST_POS = {1'b0, {(DATA_SIZE-1){1'b1}}};

    always_comb begin
        if (i_val == MOST_NEG) begin
            o_mag = MOST_POS;
        end else if (i_val[DATA_SIZE-1]) begin
            o_mag = -i_val;
        end else begin
            o_mag = i_val;
        end
    end

endmodule

// File: rtl/jacobi_pivot_search.sv
// Scans the strict upper triangle of the covariance BRAM for the largest-magnitude
// element, then fetches the matching diagonals and reports the pivot for the CORDIC stage.
module jacobi_pivot_search
    import pca_pkg::*;
#(
    parameter int DATA_SIZE    = PCA_DATA_SIZE,
    parameter int MATRIX_SIZE  = PCA_MATRIX_SIZE,
    parameter int ADDR_W       = 4,
    parameter int READ_LATENCY = 1,
    parameter int THRESHOLD    = 1,
    localparam int IDX_W       = $clog2(MATRIX_SIZE)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          douta_cov,
    output logic                 ena_cov,
    output logic [ADDR_W-1:0]    addra_cov,
    output logic [IDX_W-1:0]     p,
    output logic [IDX_W-1:0]     q,
    output logic [DATA_SIZE-1:0] c_pp,
    output logic [DATA_SIZE-1:0] c_qq,
    output logic [DATA_SIZE-1:0] c_pq,
    output logic                 pivot_valid,
    output logic                 done,
    output logic                 converged,
    output logic                 busy
);

    localparam int NUM_PAIRS = MATRIX_SIZE * (MATRIX_SIZE - 1) / 2;
    localparam int PAIR_W    = $clog2(NUM_PAIRS + 1);
    localparam int WAIT_W    = 2;
    localparam logic [WAIT_W-1:0]  LAT_LAST = WAIT_W'(READ_LATENCY - 1);
    localparam logic [DATA_SIZE:0] THR_EXT  = (DATA_SIZE + 1)'(THRESHOLD);

    pivot_state_e           r_state;
    logic [PAIR_W-1:0]      r_pairCnt;
    logic [WAIT_W-1:0]      r_waitCnt;
    read_kind_e             r_issueKind;
    logic [IDX_W-1:0]       r_issueP;
    logic [IDX_W-1:0]       r_issueQ;
    read_kind_e             r_pipeKind [READ_LATENCY];
    logic [IDX_W-1:0]       r_pipeP    [READ_LATENCY];
    logic [IDX_W-1:0]       r_pipeQ    [READ_LATENCY];
    logic [DATA_SIZE-1:0]   r_bestMag;
    logic [DATA_SIZE-1:0]   r_bestVal;
    logic [IDX_W-1:0]       r_bestP;
    logic [IDX_W-1:0]       r_bestQ;
    logic [DATA_SIZE-1:0]   r_diagPP;
    logic [DATA_SIZE-1:0]   r_diagQQ;

    logic [DATA_SIZE-1:0]   w_data;
    logic [DATA_SIZE-1:0]   w_mag;
    read_kind_e             w_tailKind;
    logic                   w_better;
    logic [DATA_SIZE-1:0]   w_nextMag;
    logic [DATA_SIZE-1:0]   w_nextVal;
    logic [IDX_W-1:0]       w_nextP;
    logic [IDX_W-1:0]       w_nextQ;
    logic [DATA_SIZE-1:0]   w_nextPP;
    logic [DATA_SIZE-1:0]   w_nextQQ;
    logic                   w_conv;
    logic [IDX_W-1:0]       w_scanRow;
    logic [IDX_W-1:0]       w_scanCol;
    logic [ADDR_W-1:0]      w_scanAddr;
    logic [ADDR_W-1:0]      w_ppAddr;
    logic [ADDR_W-1:0]      w_qqAddr;
    logic                   w_unusedHi;

    assign w_data     = douta_cov[DATA_SIZE-1:0];
    assign w_unusedHi = ^douta_cov[31:DATA_SIZE];
    assign w_tailKind = r_pipeKind[READ_LATENCY-1];

    abs_sat #(
        .DATA_SIZE (DATA_SIZE)
    ) u_abs_sat (
        .i_val (w_data),
        .o_mag (w_mag)
    );

    // Strict greater-than keeps the earliest pair on magnitude ties
    assign w_better  = (w_tailKind == RD_SCAN) && (w_mag > r_bestMag);
    assign w_nextMag = w_better ? w_mag : r_bestMag;
    assign w_nextVal = w_better ? w_data : r_bestVal;
    assign w_nextP   = w_better ? r_pipeP[READ_LATENCY-1] : r_bestP;
    assign w_nextQ   = w_better ? r_pipeQ[READ_LATENCY-1] : r_bestQ;
    assign w_nextPP  = (w_tailKind == RD_PP) ? w_data : r_diagPP;
    assign w_nextQQ  = (w_tailKind == RD_QQ) ? w_data : r_diagQQ;
    assign w_conv    = {1'b0, r_bestMag} < THR_EXT;

    assign w_scanRow  = IDX_W'(pair_row(int'(r_pairCnt), MATRIX_SIZE));
    assign w_scanCol  = IDX_W'(pair_col(int'(r_pairCnt), MATRIX_SIZE));
    assign w_scanAddr = ADDR_W'(rc_addr(int'(w_scanRow), int'(w_scanCol), MATRIX_SIZE));
    // The (p,p) read is issued on the same edge that folds in the last scan word
    assign w_ppAddr   = ADDR_W'(rc_addr(int'(w_nextP), int'(w_nextP), MATRIX_SIZE));
    assign w_qqAddr   = ADDR_W'(rc_addr(int'(r_bestQ), int'(r_bestQ), MATRIX_SIZE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_pairCnt   <= '0;
            r_waitCnt   <= '0;
            r_issueKind <= RD_NONE;
            r_issueP    <= '0;
            r_issueQ    <= '0;
            ena_cov     <= 1'b0;
            addra_cov   <= '0;
            p           <= '0;
            q           <= '0;
            c_pp        <= '0;
            c_qq        <= '0;
            c_pq        <= '0;
            pivot_valid <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_SCAN;
                        busy        <= 1'b1;
                        ena_cov     <= 1'b1;
                        addra_cov   <= w_scanAddr;
                        r_issueKind <= RD_SCAN;
                        r_issueP    <= w_scanRow;
                        r_issueQ    <= w_scanCol;
                        r_pairCnt   <= r_pairCnt + 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (r_pairCnt == PAIR_W'(NUM_PAIRS)) begin
                        ena_cov     <= 1'b0;
                        r_issueKind <= RD_NONE;
                        r_pairCnt   <= '0;
                        r_waitCnt   <= '0;
                        r_state     <= ST_DRAIN;
                    end else begin
                        addra_cov   <= w_scanAddr;
                        r_issueP    <= w_scanRow;
                        r_issueQ    <= w_scanCol;
                        r_pairCnt   <= r_pairCnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_waitCnt == LAT_LAST) begin
                        r_waitCnt   <= '0;
                        ena_cov     <= 1'b1;
                        addra_cov   <= w_ppAddr;
                        r_issueKind <= RD_PP;
                        r_state     <= ST_DIAG;
                    end else begin
                        r_waitCnt   <= r_waitCnt + 1'b1;
                    end
                end
                ST_DIAG: begin
                    if (r_waitCnt == '0) begin
                        r_waitCnt   <= r_waitCnt + 1'b1;
                        addra_cov   <= w_qqAddr;
                        r_issueKind <= RD_QQ;
                    end else begin
                        r_waitCnt   <= '0;
                        ena_cov     <= 1'b0;
                        r_issueKind <= RD_NONE;
                        r_state     <= ST_DIAG_DRAIN;
                    end
                end
                ST_DIAG_DRAIN: begin
                    if (r_waitCnt == LAT_LAST) begin
                        r_waitCnt   <= '0;
                        r_state     <= ST_REPORT;
                        done        <= 1'b1;
                        converged   <= w_conv;
                        pivot_valid <= ~w_conv;
                        p           <= r_bestP;
                        q           <= r_bestQ;
                        c_pq        <= r_bestVal;
                        c_pp        <= w_nextPP;
                        c_qq        <= w_nextQQ;
                    end else begin
                        r_waitCnt   <= r_waitCnt + 1'b1;
                    end
                end
                ST_REPORT: begin
                    done        <= 1'b0;
                    pivot_valid <= 1'b0;
                    busy        <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Read tags ride alongside the BRAM latency so every returning word is identified
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipeKind[i] <= RD_NONE;
                r_pipeP[i]    <= '0;
                r_pipeQ[i]    <= '0;
            end
            r_bestMag <= '0;
            r_bestVal <= '0;
            r_bestP   <= '0;
            r_bestQ   <= IDX_W'(1);
            r_diagPP  <= '0;
            r_diagQQ  <= '0;
        end else begin
            r_pipeKind[0] <= r_issueKind;
            r_pipeP[0]    <= r_issueP;
            r_pipeQ[0]    <= r_issueQ;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipeKind[i] <= r_pipeKind[i-1];
                r_pipeP[i]    <= r_pipeP[i-1];
                r_pipeQ[i]    <= r_pipeQ[i-1];
            end
            if (r_state == ST_IDLE) begin
                r_bestMag <= '0;
                r_bestVal <= '0;
                r_bestP   <= '0;
                r_bestQ   <= IDX_W'(1);
            end else begin
                r_bestMag <= w_nextMag;
                r_bestVal <= w_nextVal;
                r_bestP   <= w_nextP;
                r_bestQ   <= w_nextQ;
            end
            r_diagPP <= w_nextPP;
            r_diagQQ <= w_nextQQ;
        end
    end

endmodule

// File: tb/tb_jacobi_pivot_search.sv
// Directed bench for jacobi_pivot_search: one DUT at READ_LATENCY=1 and one at 2,
// each fed by a behavioural BRAM model sharing the same matrix contents.
module tb_jacobi_pivot_search;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [31:0] mem [0:15];
    logic [31:0] rd1 = '0;
    logic [31:0] rdA2 = '0;
    logic [31:0] rd2 = '0;

    logic       ena1, pv1, done1, conv1, busy1;
    logic [3:0] addr1;
    logic [1:0] p1, q1;
    logic [7:0] cpp1, cqq1, cpq1;
    logic       ena2, pv2, done2, conv2, busy2;
    logic [3:0] addr2;
    logic [1:0] p2, q2;
    logic [7:0] cpp2, cqq2, cpq2;

    int testsRun = 0;
    int testsFailed = 0;

    int sel = 1;
    logic       obsEna, obsPv, obsDone, obsBusy;
    logic [3:0] obsAddr;

    int gDoneCyc;
    int gDoneCnt;
    int gPvCnt;
    int gPvWithDone;
    logic gBusyFirst;
    int gAddrQ [$];

    int expTie [0:7] = '{1, 2, 3, 6, 7, 11, 0, 10};

    always #5 clk = ~clk;

    jacobi_pivot_search #(
        .DATA_SIZE (8), .MATRIX_SIZE (4), .ADDR_W (4), .READ_LATENCY (1), .THRESHOLD (1)
    ) dut1 (
        .clk (clk), .rst (rst), .start (start1), .douta_cov (rd1),
        .ena_cov (ena1), .addra_cov (addr1), .p (p1), .q (q1),
        .c_pp (cpp1), .c_qq (cqq1), .c_pq (cpq1), .pivot_valid (pv1),
        .done (done1), .converged (conv1), .busy (busy1)
    );

    jacobi_pivot_search #(
        .DATA_SIZE (8), .MATRIX_SIZE (4), .ADDR_W (4), .READ_LATENCY (2), .THRESHOLD (1)
    ) dut2 (
        .clk (clk), .rst (rst), .start (start2), .douta_cov (rd2),
        .ena_cov (ena2), .addra_cov (addr2), .p (p2), .q (q2),
        .c_pp (cpp2), .c_qq (cqq2), .c_pq (cpq2), .pivot_valid (pv2),
        .done (done2), .converged (conv2), .busy (busy2)
    );

    always @(posedge clk) begin
        if (ena1) rd1 <= mem[addr1];
    end

    always @(posedge clk) begin
        if (ena2) rdA2 <= mem[addr2];
        rd2 <= rdA2;
    end

    always_comb begin
        if (sel == 2) begin
            obsEna = ena2; obsAddr = addr2; obsPv = pv2; obsDone = done2; obsBusy = busy2;
        end else begin
            obsEna = ena1; obsAddr = addr1; obsPv = pv1; obsDone = done1; obsBusy = busy1;
        end
    end

    // Lower triangle holds 127 and upper data bits hold noise, so neither may leak in
    task automatic fill_matrix(input logic [7:0] diag);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r == c) mem[r*4+c] = {24'h5A5A5A, diag};
                else if (c > r) mem[r*4+c] = {24'hC3C3C3, 8'h00};
                else mem[r*4+c] = {24'h3C3C3C, 8'h7F};
            end
        end
    endtask

    task automatic set_elem(input int r, input int c, input logic [7:0] v);
        mem[r*4+c] = {24'hC3C3C3, v};
    endtask

    task automatic load_matrix2();
        fill_matrix(8'd0);
        set_elem(0, 0, 8'd1);  set_elem(1, 1, 8'd30);
        set_elem(2, 2, 8'd2);  set_elem(3, 3, 8'hF9);
        set_elem(0, 1, 8'd5);  set_elem(0, 2, 8'hEC);
        set_elem(0, 3, 8'd20); set_elem(1, 2, 8'd12);
        set_elem(1, 3, 8'hCE); set_elem(2, 3, 8'd3);
    endtask

    task automatic run_search(input int which);
        sel = which;
        gDoneCyc = -1; gDoneCnt = 0; gPvCnt = 0; gPvWithDone = 0; gBusyFirst = 1'b0;
        gAddrQ.delete();
        @(negedge clk);
        if (which == 2) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 1) gBusyFirst = obsBusy;
            if (obsEna) gAddrQ.push_back(int'(obsAddr));
            if (obsDone) begin
                gDoneCnt++;
                if (gDoneCyc < 0) gDoneCyc = cyc;
            end
            if (obsPv) begin
                gPvCnt++;
                if (obsDone) gPvWithDone++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        testsRun++;
        if ({ena1, addr1, p1, q1, cpp1, cqq1, cpq1, pv1, done1, conv1, busy1} !== 37'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs_rl1: got %h expected 0",
                     {ena1, addr1, p1, q1, cpp1, cqq1, cpq1, pv1, done1, conv1, busy1});
        end
        testsRun++;
        if ({ena2, addr2, p2, q2, cpp2, cqq2, cpq2, pv2, done2, conv2, busy2} !== 37'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs_rl2: got %h expected 0",
                     {ena2, addr2, p2, q2, cpp2, cqq2, cpq2, pv2, done2, conv2, busy2});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        fill_matrix(8'd10);
        run_search(1);
        testsRun++;
        if (gDoneCyc !== 11) begin testsFailed++; $display("[TB] FAIL ident_done_cycle: got %0d expected 11", gDoneCyc); end
        testsRun++;
        if (gBusyFirst !== 1'b1) begin testsFailed++; $display("[TB] FAIL ident_busy_cycle1: got %b expected 1", gBusyFirst); end
        testsRun++;
        if (conv1 !== 1'b1) begin testsFailed++; $display("[TB] FAIL ident_converged: got %b expected 1", conv1); end
        testsRun++;
        if (gPvCnt !== 0) begin testsFailed++; $display("[TB] FAIL ident_pivot_valid_count: got %0d expected 0", gPvCnt); end
        testsRun++;
        if ({p1, q1} !== {2'd0, 2'd1}) begin testsFailed++; $display("[TB] FAIL ident_pq: got %0d,%0d expected 0,1", p1, q1); end
        testsRun++;
        if ({cpq1, cpp1, cqq1} !== {8'd0, 8'd10, 8'd10}) begin
            testsFailed++; $display("[TB] FAIL ident_values: got pq=%h pp=%h qq=%h expected 00 0a 0a", cpq1, cpp1, cqq1);
        end
    endtask

    task automatic test_max_pivot();
        load_matrix2();
        run_search(1);
        testsRun++;
        if (gDoneCyc !== 11) begin testsFailed++; $display("[TB] FAIL max_done_cycle: got %0d expected 11", gDoneCyc); end
        testsRun++;
        if ({p1, q1} !== {2'd1, 2'd3}) begin testsFailed++; $display("[TB] FAIL max_pq: got %0d,%0d expected 1,3", p1, q1); end
        testsRun++;
        if (cpq1 !== 8'hCE) begin testsFailed++; $display("[TB] FAIL max_c_pq: got %h expected ce", cpq1); end
        testsRun++;
        if ({cpp1, cqq1} !== {8'h1E, 8'hF9}) begin testsFailed++; $display("[TB] FAIL max_diag: got %h %h expected 1e f9", cpp1, cqq1); end
        testsRun++;
        if (gPvCnt !== 1 || gPvWithDone !== 1) begin
            testsFailed++; $display("[TB] FAIL max_pivot_pulse: got %0d cycles (%0d with done) expected 1 (1)", gPvCnt, gPvWithDone);
        end
        testsRun++;
        if (conv1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL max_converged: got %b expected 0", conv1); end
        testsRun++;
        if (gDoneCnt !== 1) begin testsFailed++; $display("[TB] FAIL max_done_count: got %0d expected 1", gDoneCnt); end
    endtask

    task automatic test_tie();
        fill_matrix(8'd9);
        set_elem(0, 0, 8'd4);  set_elem(2, 2, 8'd6);
        set_elem(0, 1, 8'd1);  set_elem(0, 2, 8'd40);
        set_elem(0, 3, 8'hFD); set_elem(1, 2, 8'd0);
        set_elem(1, 3, 8'd39); set_elem(2, 3, 8'hD8);
        run_search(1);
        testsRun++;
        if ({p1, q1} !== {2'd0, 2'd2}) begin testsFailed++; $display("[TB] FAIL tie_pq: got %0d,%0d expected 0,2", p1, q1); end
        testsRun++;
        if ({cpq1, cpp1, cqq1} !== {8'h28, 8'd4, 8'd6}) begin
            testsFailed++; $display("[TB] FAIL tie_values: got pq=%h pp=%h qq=%h expected 28 04 06", cpq1, cpp1, cqq1);
        end
        testsRun++;
        if (gAddrQ.size() !== 8) begin
            testsFailed++; $display("[TB] FAIL tie_addr_count: got %0d expected 8", gAddrQ.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                testsRun++;
                if (gAddrQ[i] !== expTie[i]) begin
                    testsFailed++; $display("[TB] FAIL tie_addr_%0d: got %0d expected %0d", i, gAddrQ[i], expTie[i]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        fill_matrix(8'd0);
        set_elem(1, 1, 8'd11); set_elem(2, 2, 8'd22);
        set_elem(0, 1, 8'h64); set_elem(0, 2, 8'h9C);
        set_elem(0, 3, 8'h63); set_elem(1, 2, 8'h80);
        set_elem(1, 3, 8'h9D); set_elem(2, 3, 8'h00);
        run_search(1);
        testsRun++;
        if ({p1, q1, cpq1} !== {2'd1, 2'd2, 8'h80}) begin
            testsFailed++; $display("[TB] FAIL sat_min_pivot: got %0d,%0d c_pq=%h expected 1,2 80", p1, q1, cpq1);
        end
        testsRun++;
        if ({cpp1, cqq1} !== {8'h0B, 8'h16}) begin testsFailed++; $display("[TB] FAIL sat_min_diag: got %h %h expected 0b 16", cpp1, cqq1); end
        // -128 saturates to 127, which only ties the earlier +127
        fill_matrix(8'd0);
        set_elem(0, 0, 8'd3);  set_elem(1, 1, 8'd5);
        set_elem(0, 1, 8'h7F); set_elem(0, 2, 8'h80);
        run_search(1);
        testsRun++;
        if ({p1, q1, cpq1} !== {2'd0, 2'd1, 8'h7F}) begin
            testsFailed++; $display("[TB] FAIL sat_tie_pivot: got %0d,%0d c_pq=%h expected 0,1 7f", p1, q1, cpq1);
        end
        testsRun++;
        if ({cpp1, cqq1} !== {8'd3, 8'd5}) begin testsFailed++; $display("[TB] FAIL sat_tie_diag: got %h %h expected 03 05", cpp1, cqq1); end
    endtask

    task automatic test_back_to_back();
        int firstDone;
        int secondDone;
        int doneCount;
        logic busyIdle;
        logic busyRestart;
        load_matrix2();
        sel = 1; firstDone = -1; secondDone = -1; doneCount = 0; busyIdle = 1'b1; busyRestart = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 26; cyc++) begin
            if (done1) begin
                doneCount++;
                if (firstDone < 0) firstDone = cyc; else if (secondDone < 0) secondDone = cyc;
            end
            if (cyc == 12) busyIdle = busy1;
            if (cyc == 13) busyRestart = busy1;
            if (cyc == 23) start1 = 1'b0;
            @(posedge clk); #1;
        end
        start1 = 1'b0;
        testsRun++;
        if (firstDone !== 11 || secondDone !== 23) begin
            testsFailed++; $display("[TB] FAIL b2b_done_cycles: got %0d,%0d expected 11,23", firstDone, secondDone);
        end
        testsRun++;
        if (doneCount !== 2) begin testsFailed++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", doneCount); end
        testsRun++;
        if (busyIdle !== 1'b0 || busyRestart !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL b2b_busy: got idle=%b restart=%b expected 0 1", busyIdle, busyRestart);
        end
    endtask

    task automatic test_abort_reset();
        int doneSeen;
        logic [3:0] addrAt5;
        logic busyAt5;
        load_matrix2();
        sel = 1; doneSeen = 0; addrAt5 = '0; busyAt5 = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            if (done1) doneSeen++;
            if (cyc == 4) start1 = 1'b1;
            if (cyc == 5) begin
                start1 = 1'b0;
                addrAt5 = addr1;
                busyAt5 = busy1;
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        testsRun++;
        if ({addrAt5, busyAt5} !== {4'd7, 1'b1}) begin
            testsFailed++; $display("[TB] FAIL abort_second_start: got addr=%0d busy=%b expected 7 1", addrAt5, busyAt5);
        end
        testsRun++;
        if ({ena1, addr1, p1, q1, cpp1, cqq1, cpq1, pv1, done1, conv1, busy1} !== 37'd0) begin
            testsFailed++;
            $display("[TB] FAIL abort_reset_outputs: got %h expected 0",
                     {ena1, addr1, p1, q1, cpp1, cqq1, cpq1, pv1, done1, conv1, busy1});
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (done1) doneSeen++;
        end
        testsRun++;
        if (doneSeen !== 0) begin testsFailed++; $display("[TB] FAIL abort_no_done: got %0d done cycles expected 0", doneSeen); end
        @(negedge clk);
        rst = 1'b1;
        run_search(1);
        testsRun++;
        if (gDoneCyc !== 11 || {p1, q1, cpq1} !== {2'd1, 2'd3, 8'hCE}) begin
            testsFailed++; $display("[TB] FAIL abort_fresh_search: got cycle=%0d p=%0d q=%0d c_pq=%h expected 11 1 3 ce",
                                    gDoneCyc, p1, q1, cpq1);
        end
    endtask

    task automatic test_latency2();
        load_matrix2();
        run_search(2);
        testsRun++;
        if (gDoneCyc !== 13) begin testsFailed++; $display("[TB] FAIL lat2_done_cycle: got %0d expected 13", gDoneCyc); end
        testsRun++;
        if ({p2, q2, cpq2} !== {2'd1, 2'd3, 8'hCE}) begin
            testsFailed++; $display("[TB] FAIL lat2_pivot: got %0d,%0d c_pq=%h expected 1,3 ce", p2, q2, cpq2);
        end
        testsRun++;
        if ({cpp2, cqq2} !== {8'h1E, 8'hF9}) begin testsFailed++; $display("[TB] FAIL lat2_diag: got %h %h expected 1e f9", cpp2, cqq2); end
        testsRun++;
        if (gPvCnt !== 1 || conv2 !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL lat2_pulse: got pv=%0d conv=%b expected 1 0", gPvCnt, conv2);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_identity();
        test_max_pivot();
        test_tie();
        test_saturation();
        test_back_to_back();
        test_abort_reset();
        test_latency2();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
